// File: rtl/pll_reset_sequencer.sv
// Lock qualifier and ordered memory/CPU reset release behind the PLL.
// Optional PLL watchdog request: define PLL_RESET_SEQ_WDOG_EN.
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP          = 16,
  parameter int LOSS_CNT_W         = 8,
  parameter int WDOG_CYCLES        = 65536
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic                  rst_mem_out,
  output logic                  rst_cpu_out,
  output logic                  run_en,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [1:0]            seq_state
`ifdef PLL_RESET_SEQ_WDOG_EN
  ,output logic                 pll_rst_req
`endif
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    REL_MEM   = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STAGE_GAP) ?
                           LOCK_STABLE_CYCLES : STAGE_GAP;
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  logic [1:0]            sync_q;
  logic                  locked_s;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  loss_bump;

  assign locked_s      = sync_q[1];
  assign seq_state     = state_q;
  assign lock_loss_cnt = loss_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    loss_bump = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) state_d = STABLE;
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = REL_MEM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL_MEM: begin
        if (!locked_s) begin
          state_d   = WAIT_LOCK;
          cnt_d     = '0;
          loss_bump = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d   = WAIT_LOCK;
          loss_bump = 1'b1;
        end
      end
    endcase
    // saturate rather than wrap so a debugger sees "many"
    loss_d = (loss_bump && (loss_q != '1)) ? loss_q + 1'b1 : loss_q;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q      <= 2'b00;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      loss_q      <= '0;
      rst_mem_out <= 1'b1;
      rst_cpu_out <= 1'b1;
      run_en      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], pll_locked};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_q      <= loss_d;
      rst_mem_out <= (state_d == WAIT_LOCK) || (state_d == STABLE);
      rst_cpu_out <= (state_d != RUN);
      run_en      <= (state_d == RUN);
    end
  end

`ifdef PLL_RESET_SEQ_WDOG_EN
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic [1:0]      pcnt_q, pcnt_d;
  logic            req_d;
  logic            fire;

  assign fire = (state_q == WAIT_LOCK) && (wdog_q == WD_LAST);

  always_comb begin
    wdog_d = '0;
    if (state_q == WAIT_LOCK) wdog_d = fire ? '0 : wdog_q + 1'b1;
    pcnt_d = '0;
    req_d  = 1'b0;
    // pulse runs to completion even if lock arrives mid-pulse
    if (fire) begin
      pcnt_d = 2'd3;
      req_d  = 1'b1;
    end else if (pcnt_q != 2'd0) begin
      pcnt_d = pcnt_q - 1'b1;
      req_d  = 1'b1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      wdog_q      <= '0;
      pcnt_q      <= '0;
      pll_rst_req <= 1'b0;
    end else begin
      wdog_q      <= wdog_d;
      pcnt_q      <= pcnt_d;
      pll_rst_req <= req_d;
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: vector table plus
// hand sequences for loss saturation and the optional watchdog.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_r;
  logic       lk;
  logic       mem_a, cpu_a, run_a;
  logic [7:0] loss_a;
  logic [1:0] st_a;
  logic       mem_b, cpu_b, run_b;
  logic [1:0] loss_b;
  logic [1:0] st_b;
`ifdef PLL_RESET_SEQ_WDOG_EN
  logic       req_a, req_b;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(8), .STAGE_GAP(4),
    .LOSS_CNT_W(8), .WDOG_CYCLES(16)
  ) dut_a (
    .refclk(clk), .rst(rst_r), .pll_locked(lk),
    .rst_mem_out(mem_a), .rst_cpu_out(cpu_a), .run_en(run_a),
    .lock_loss_cnt(loss_a), .seq_state(st_a)
`ifdef PLL_RESET_SEQ_WDOG_EN
    ,.pll_rst_req(req_a)
`endif
  );

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(8), .STAGE_GAP(4),
    .LOSS_CNT_W(2), .WDOG_CYCLES(16)
  ) dut_b (
    .refclk(clk), .rst(rst_r), .pll_locked(lk),
    .rst_mem_out(mem_b), .rst_cpu_out(cpu_b), .run_en(run_b),
    .lock_loss_cnt(loss_b), .seq_state(st_b)
`ifdef PLL_RESET_SEQ_WDOG_EN
    ,.pll_rst_req(req_b)
`endif
  );

  typedef struct {
    logic       r;
    logic       l;
    int         n;
    logic       mem;
    logic       cpu;
    logic       run;
    logic [1:0] st;
    logic [7:0] loss;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic l, input int n);
    rst_r = r;
    lk    = l;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] sat2(input logic [7:0] v);
    return (v > 8'd3) ? 2'd3 : v[1:0];
  endfunction

  initial begin
    logic [7:0] exp_loss;
    rst_r = 1'b1;
    lk    = 1'b1;
    //          r  l   n  mem cpu run st loss
    tbl[0]  = '{1, 1,  3, 1,  1,  0,  0, 0};
    tbl[1]  = '{0, 1, 10, 1,  1,  0,  1, 0};
    tbl[2]  = '{0, 1,  1, 0,  1,  0,  2, 0};
    tbl[3]  = '{0, 1,  3, 0,  1,  0,  2, 0};
    tbl[4]  = '{0, 1,  1, 0,  0,  1,  3, 0};
    tbl[5]  = '{0, 0,  2, 0,  0,  1,  3, 0};
    tbl[6]  = '{0, 0,  1, 1,  1,  0,  0, 1};
    tbl[7]  = '{0, 0,  1, 1,  1,  0,  0, 1};
    tbl[8]  = '{0, 1, 10, 1,  1,  0,  1, 1};
    tbl[9]  = '{0, 1,  1, 0,  1,  0,  2, 1};
    tbl[10] = '{0, 1,  4, 0,  0,  1,  3, 1};
    tbl[11] = '{0, 0,  3, 1,  1,  0,  0, 2};
    tbl[12] = '{0, 1,  5, 1,  1,  0,  1, 2};
    tbl[13] = '{0, 0,  3, 1,  1,  0,  0, 2};
    tbl[14] = '{0, 1, 10, 1,  1,  0,  1, 2};
    tbl[15] = '{0, 1,  1, 0,  1,  0,  2, 2};
    tbl[16] = '{0, 1,  2, 0,  1,  0,  2, 2};
    tbl[17] = '{1, 1,  1, 1,  1,  0,  0, 0};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].r, tbl[i].l, tbl[i].n);
      chk($sformatf("v%0d.mem", i), 32'(mem_a), 32'(tbl[i].mem));
      chk($sformatf("v%0d.cpu", i), 32'(cpu_a), 32'(tbl[i].cpu));
      chk($sformatf("v%0d.run", i), 32'(run_a), 32'(tbl[i].run));
      chk($sformatf("v%0d.st", i), 32'(st_a), 32'(tbl[i].st));
      chk($sformatf("v%0d.loss", i), 32'(loss_a), 32'(tbl[i].loss));
      chk($sformatf("v%0d.loss2", i), 32'(loss_b),
          32'(sat2(tbl[i].loss)));
      chk($sformatf("v%0d.st2", i), 32'(st_b), 32'(tbl[i].st));
    end

    // five losses from RUN: narrow counter must stick at 3
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 15);
      chk($sformatf("sat%0d.run", i), 32'(run_a), 32'd1);
      chk($sformatf("sat%0d.st", i), 32'(st_b), 32'd3);
      step(1'b0, 1'b0, 3);
      exp_loss = 8'(i + 1);
      chk($sformatf("sat%0d.loss", i), 32'(loss_a), 32'(exp_loss));
      chk($sformatf("sat%0d.loss2", i), 32'(loss_b),
          32'(sat2(exp_loss)));
      chk($sformatf("sat%0d.run2", i), 32'(run_b), 32'd0);
    end

`ifdef PLL_RESET_SEQ_WDOG_EN
    step(1'b1, 1'b0, 2);
    chk("wd.rst", 32'(req_a), 32'd0);
    step(1'b0, 1'b0, 15);
    chk("wd.e15", 32'(req_a), 32'd0);
    step(1'b0, 1'b0, 1);
    chk("wd.e16", 32'(req_a), 32'd1);
    step(1'b0, 1'b0, 3);
    chk("wd.e19", 32'(req_a), 32'd1);
    step(1'b0, 1'b0, 1);
    chk("wd.e20", 32'(req_a), 32'd0);
    step(1'b0, 1'b0, 12);
    chk("wd.e32", 32'(req_a), 32'd1);
    step(1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 16);
    chk("wd2.e16", 32'(req_a), 32'd1);
    step(1'b0, 1'b1, 3);
    chk("wd2.e19", 32'(req_a), 32'd1);
    step(1'b0, 1'b1, 1);
    chk("wd2.e20", 32'(req_a), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
